// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random source with seed load, lock-up recovery,
// rejection-sampled range limiting and a valid/ready sample port.
module lfsr_rng #(
  parameter int unsigned        WIDTH = 8,
  parameter logic [WIDTH-1:0]   TAPS  = 8'b0001_1101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] limit,
  input  logic             rnd_ready,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd_data,
  output logic [WIDTH-1:0] lfsr_q,
  output logic             wrap,
  output logic [15:0]      reject_cnt
);

  typedef enum logic {
    S_SEARCH = 1'b0,
    S_VALID  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_data;
  logic             r_wrap;
  logic [15:0]      r_rej;

  logic             w_step;
  logic             w_fb;
  logic [WIDTH-1:0] w_lfsr_step;
  logic [WIDTH-1:0] w_lfsr_nxt;
  logic             w_accept;
  logic             w_capture;
  logic             w_reject;

  assign w_step = en & ~load;
  assign w_fb   = ~^(r_lfsr & TAPS);

  // XNOR feedback never leaves all-ones on its own, so force it out to zero.
  assign w_lfsr_step = (r_lfsr == '1) ? '0 : {w_fb, r_lfsr[WIDTH-1:1]};

  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (load) begin
      w_lfsr_nxt = (seed == '1) ? '0 : seed;
    end else if (en) begin
      w_lfsr_nxt = w_lfsr_step;
    end
  end

  assign w_accept = (limit == '0) || (r_lfsr < limit);

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_reject    = 1'b0;
    if (load) begin
      w_state_nxt = S_SEARCH;
    end else begin
      unique case (r_state)
        S_SEARCH: begin
          if (w_step) begin
            if (w_accept) begin
              w_capture   = 1'b1;
              w_state_nxt = S_VALID;
            end else begin
              w_reject = 1'b1;
            end
          end
        end
        S_VALID: begin
          // With the consumer stalled, candidates pass by unseen and uncounted.
          if (rnd_ready) begin
            if (w_step && w_accept) begin
              w_capture = 1'b1;
            end else begin
              w_state_nxt = S_SEARCH;
              w_reject    = w_step;
            end
          end
        end
        default: w_state_nxt = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_SEARCH;
      r_lfsr  <= '0;
      r_data  <= '0;
      r_wrap  <= 1'b0;
      r_rej   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_wrap  <= w_step && (w_lfsr_step == '0);
      if (load) begin
        r_data <= '0;
      end else if (w_capture) begin
        r_data <= r_lfsr;
      end
      if (load) begin
        r_rej <= '0;
      end else if (w_reject && (r_rej != '1)) begin
        r_rej <= r_rej + 16'd1;
      end
    end
  end

  assign rnd_valid  = (r_state == S_VALID);
  assign rnd_data   = r_data;
  assign lfsr_q     = r_lfsr;
  assign wrap       = r_wrap;
  assign reject_cnt = r_rej;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng with the default 8-bit polynomial.
module tb_lfsr_rng;

  logic        clk = 1'b0;
  logic        rst, en, load, rnd_ready;
  logic [7:0]  seed, limit;
  logic        rnd_valid, wrap;
  logic [7:0]  rnd_data, lfsr_q;
  logic [15:0] reject_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  lfsr_rng #(.WIDTH(8), .TAPS(8'b0001_1101)) u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed), .limit(limit),
    .rnd_ready(rnd_ready), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .lfsr_q(lfsr_q), .wrap(wrap), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] nx(input logic [7:0] x);
    if (x == 8'hFF) return 8'h00;
    return {~^(x & 8'h1D), x[7:1]};
  endfunction

  logic [7:0] ev [7] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'h78, 8'hBC};

  initial begin
    logic [7:0]  m;
    int unsigned seq_err, bad_wrap, distinct, bad, x1, x2, d1, d2;
    logic        seen [256];
    logic        s1 [256];
    logic        s2 [256];

    rst = 1'b1; en = 1'b0; load = 1'b0; seed = '0; limit = '0; rnd_ready = 1'b0;
    step(); step();
    chk("rst_lfsr", lfsr_q, 0);
    chk("rst_valid", rnd_valid, 0);
    chk("rst_data", rnd_data, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_rej", reject_cnt, 0);

    // Default sequence, period and wrap pulses.
    rst = 1'b0; en = 1'b1;
    m = 8'h00; seq_err = 0; bad_wrap = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (k < 7) chk($sformatf("seq%0d", k), lfsr_q, ev[k]);
      if (lfsr_q !== m) seq_err++;
      if (k < 255) seen[lfsr_q] = 1'b1;
      if (k == 255 || k == 510) chk($sformatf("wrap_at_%0d", k), wrap, 1);
      else if (wrap !== 1'b0) bad_wrap++;
      m = nx(m);
      step();
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    chk("seq_model", seq_err, 0);
    chk("distinct_255", distinct, 255);
    chk("ff_absent", seen[255], 0);
    chk("stray_wrap", bad_wrap, 0);
    chk("bp_rej_zero", reject_cnt, 0);
    chk("first_held", rnd_data, 8'h00);

    // Unlimited back-to-back stream.
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b1; rnd_ready = 1'b1; limit = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("ul_valid%0d", i), rnd_valid, 1);
      chk($sformatf("ul_data%0d", i), rnd_data, ev[i]);
    end
    chk("ul_rej", reject_cnt, 0);

    // Range limiting by rejection.
    rst = 1'b1; step();
    rst = 1'b0; limit = 8'h10;
    bad = 0; x1 = 0; x2 = 0;
    for (int i = 0; i < 256; i++) begin s1[i] = 1'b0; s2[i] = 1'b0; end
    for (int k = 1; k <= 600; k++) begin
      step();
      if (rnd_valid) begin
        if (rnd_data >= 8'h10) bad++;
        if (k <= 255) begin s1[rnd_data] = 1'b1; x1++; end
        else if (k <= 510) begin s2[rnd_data] = 1'b1; x2++; end
      end
      if (k == 255) chk("rej_p1", reject_cnt, 239);
      if (k == 510) chk("rej_p2", reject_cnt, 478);
    end
    d1 = 0; d2 = 0;
    for (int i = 0; i < 256; i++) begin
      if (s1[i]) d1++;
      if (s2[i]) d2++;
    end
    chk("lim_oob", bad, 0);
    chk("lim_distinct1", d1, 16);
    chk("lim_xfer1", x1, 16);
    chk("lim_distinct2", d2, 16);
    chk("lim_xfer2", x2, 16);

    // Seed load, all-ones coercion.
    load = 1'b1; seed = 8'hFF; limit = '0; rnd_ready = 1'b0;
    step();
    chk("ld_ff_lfsr", lfsr_q, 0);
    chk("ld_ff_valid", rnd_valid, 0);
    chk("ld_ff_rej", reject_cnt, 0);
    chk("ld_ff_wrap", wrap, 0);
    seed = 8'h5A;
    step();
    chk("ld_5a", lfsr_q, 8'h5A);
    load = 1'b0;
    step();
    chk("step_ad", lfsr_q, 8'hAD);
    chk("ld_valid", rnd_valid, 1);
    chk("ld_data", rnd_data, 8'h5A);

    // Backpressure, then freeze and a single handshake.
    limit = 8'h10; m = 8'hAD; bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      m = nx(m);
      if (rnd_data !== 8'h5A || rnd_valid !== 1'b1) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_rej", reject_cnt, 0);
    chk("bp_lfsr", lfsr_q, m);
    en = 1'b0; rnd_ready = 1'b1;
    step();
    chk("fz_xfer", rnd_valid, 0);
    chk("fz_lfsr1", lfsr_q, m);
    step();
    chk("fz_once", rnd_valid, 0);
    chk("fz_lfsr2", lfsr_q, m);
    chk("fz_rej", reject_cnt, 0);

    // Reset beats load while a sample is pending.
    en = 1'b1; limit = '0; rnd_ready = 1'b0;
    step();
    chk("pre_rst_valid", rnd_valid, 1);
    rst = 1'b1; load = 1'b1; seed = 8'h5A;
    step();
    chk("mr_lfsr", lfsr_q, 0);
    chk("mr_valid", rnd_valid, 0);
    chk("mr_data", rnd_data, 0);
    chk("mr_wrap", wrap, 0);
    chk("mr_rej", reject_cnt, 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
